// File: rtl/store_unit.sv
// Store unit: commits word stores directly and sub-word stores via read-modify-write
// on a big-endian, word-organised data memory (bit 0 is the MSB).
module store_unit #(
  parameter int READ_LAT = 1  // legal range 1..4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_req,
  input  logic [0:31] st_addr,
  input  logic [0:31] st_data,
  input  logic [0:2]  dmem_info,
  output logic [0:31] mem_addr,
  output logic        mem_rd,
  input  logic [0:31] mem_rdata,
  output logic        mem_wr,
  output logic [0:31] mem_wdata,
  output logic        busy,
  output logic        st_done,
  output logic        st_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [0:29] waddr_q;
  logic [0:1]  lane_q;
  logic [0:31] data_q;
  logic        word_q;
  logic        half_q;
  logic [2:0]  cnt_q;
  logic [0:31] merged_q;
  logic [0:31] merge_w;

  logic req_word, req_half, req_misal;
  logic unused_info;

  // Word flag outranks halfword flag; the unsigned flag means nothing for stores.
  assign req_word    = dmem_info[1];
  assign req_half    = !dmem_info[1] && dmem_info[2];
  assign req_misal   = (req_word && (st_addr[30:31] != 2'b00)) || (req_half && st_addr[31]);
  assign unused_info = dmem_info[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (st_req) state_d = req_misal ? S_ERR : (req_word ? S_WRITE : S_READ);
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 3'd1) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane merge: halfword stores cover the lane pair chosen by addr[30].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    localparam int         HOFF = 16 + 8 * (gi % 2);
    logic sel;
    assign sel = half_q ? (lane_q[0] == LANE[1]) : (lane_q == LANE);
    assign merge_w[8*gi +: 8] = !sel ? mem_rdata[8*gi +: 8]
                              : (half_q ? data_q[HOFF +: 8] : data_q[24:31]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr_q  <= '0;
      lane_q   <= '0;
      data_q   <= '0;
      word_q   <= 1'b0;
      half_q   <= 1'b0;
      cnt_q    <= '0;
      merged_q <= '0;
    end else begin
      if (state_q == S_IDLE && st_req) begin
        waddr_q <= st_addr[0:29];
        lane_q  <= st_addr[30:31];
        data_q  <= st_data;
        word_q  <= req_word;
        half_q  <= req_half;
      end
      if (state_q == S_READ) cnt_q <= 3'(READ_LAT);
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) merged_q <= merge_w;
      end
    end
  end

  // All outputs decode from registered state, so reset clears them without a clock.
  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    st_done   = 1'b0;
    st_err    = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_READ: begin
        mem_rd   = 1'b1;
        mem_addr = {waddr_q, 2'b00};
      end
      S_WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = {waddr_q, 2'b00};
        mem_wdata = word_q ? data_q : merged_q;
      end
      S_DONE: st_done = 1'b1;
      S_ERR: begin
        st_done = 1'b1;
        st_err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: two instances (READ_LAT 1 and 3) against a latency-accurate memory model.
module tb_store_unit;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        st_req_s   [N];
  logic [0:31] st_addr_s  [N];
  logic [0:31] st_data_s  [N];
  logic [0:2]  info_s     [N];
  logic [0:31] mem_addr_s [N];
  logic [0:31] mem_rdata_s[N];
  logic [0:31] mem_wdata_s[N];
  logic        mem_rd_s   [N];
  logic        mem_wr_s   [N];
  logic        busy_s     [N];
  logic        done_s     [N];
  logic        err_s      [N];

  bit [31:0] mem  [N][256];
  bit [31:0] refm [N][256];

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int RL = (gi == 0) ? 1 : 3;
    bit [31:0] pipe_d [1:4];
    bit        pipe_v [1:4];

    store_unit #(.READ_LAT(RL)) dut (
      .clk(clk), .reset_n(reset_n),
      .st_req(st_req_s[gi]), .st_addr(st_addr_s[gi]), .st_data(st_data_s[gi]),
      .dmem_info(info_s[gi]),
      .mem_addr(mem_addr_s[gi]), .mem_rd(mem_rd_s[gi]), .mem_rdata(mem_rdata_s[gi]),
      .mem_wr(mem_wr_s[gi]), .mem_wdata(mem_wdata_s[gi]),
      .busy(busy_s[gi]), .st_done(done_s[gi]), .st_err(err_s[gi])
    );

    // Read data is valid only in the single cycle RL cycles after the strobe.
    always @(posedge clk) begin
      pipe_v[1] <= reset_n && mem_rd_s[gi];
      pipe_d[1] <= mem[gi][mem_addr_s[gi][22:29]];
      for (int i = 2; i <= 4; i++) begin
        pipe_v[i] <= reset_n && pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
    assign mem_rdata_s[gi] = pipe_v[RL] ? pipe_d[RL] : 32'hA5A5_5A5A;
  end

  typedef struct {
    int        lat;
    int        err_cnt;
    int        done_cnt;
    int        rd_cnt;
    int        wr_cnt;
    int        rd_cyc;
    int        wr_cyc;
    bit [31:0] rd_addr;
    bit [31:0] wr_addr;
    bit [31:0] wdata;
    int        busy_cnt;
    int        stray;
    bit        overlap;
    bit        idle_after;
  } mon_t;

  typedef struct {
    bit [31:0] init;
    bit [31:0] a;
    bit [31:0] d;
    bit [2:0]  inf;
    bit [31:0] exp_w;
    bit        exp_err;
    int        exp_lat1;
  } vec_t;

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference rules: info value bit1 = word, bit0 = halfword, bit2 = unsigned (no effect).
  function automatic void model(input bit [31:0] old, input bit [31:0] a, input bit [31:0] d,
                                input bit [2:0] inf, input int rl,
                                output bit err, output bit [31:0] nw, output int lat);
    int sh;
    if (inf[1]) begin
      err = (a % 4) != 0;
      nw  = d;
      lat = 2;
    end else if (inf[0]) begin
      err = (a % 2) != 0;
      sh  = ((a % 4) == 0) ? 16 : 0;
      nw  = (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      lat = 3 + rl;
    end else begin
      err = 1'b0;
      sh  = (3 - int'(a % 4)) * 8;
      nw  = (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      lat = 3 + rl;
    end
    if (err) begin
      nw  = old;
      lat = 1;
    end
  endfunction

  task automatic issue(input int k, input bit [31:0] a, input bit [31:0] d, input bit [2:0] inf);
    @(negedge clk);
    st_req_s[k]  = 1'b1;
    st_addr_s[k] = a;
    st_data_s[k] = d;
    info_s[k]    = inf;
    @(posedge clk);
    #1;
    st_req_s[k]  = 1'b0;
    st_addr_s[k] = $urandom;
    st_data_s[k] = $urandom;
    info_s[k]    = 3'($urandom);
  endtask

  // Watches cycles 1..20 after the request edge, then the cycle after completion.
  task automatic monitor(input int k, output mon_t m);
    m = '{default: 0};
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy_s[k]) m.busy_cnt++;
      if (mem_rd_s[k]) begin
        m.rd_cnt++; m.rd_cyc = n; m.rd_addr = mem_addr_s[k];
        if (mem_wdata_s[k] != 0) m.stray++;
      end
      if (mem_wr_s[k]) begin
        m.wr_cnt++; m.wr_cyc = n; m.wr_addr = mem_addr_s[k]; m.wdata = mem_wdata_s[k];
        mem[k][mem_addr_s[k][22:29]] = mem_wdata_s[k];
      end
      if (mem_rd_s[k] && mem_wr_s[k]) m.overlap = 1'b1;
      if (!mem_rd_s[k] && !mem_wr_s[k] && (mem_addr_s[k] != 0 || mem_wdata_s[k] != 0)) m.stray++;
      if (err_s[k]) m.err_cnt++;
      if (done_s[k]) begin
        m.done_cnt++;
        m.lat = n;
        break;
      end
    end
    if (m.lat != 0) begin
      @(negedge clk);
      m.idle_after = !busy_s[k] && !done_s[k] && !mem_rd_s[k] && !mem_wr_s[k];
    end
  endtask

  task automatic do_txn(input int k, input bit [31:0] a, input bit [31:0] d, input bit [2:0] inf,
                        input bit exp_err, input bit [31:0] exp_w, input int exp_lat,
                        input bit [31:0] exp_mem, output int lat);
    mon_t m;
    bit   sub;
    sub = !exp_err && !inf[1];
    issue(k, a, d, inf);
    monitor(k, m);
    $display("txn dut%0d addr=%h data=%h info=%b lat=%0d wr=%0d wdata=%h err=%0d",
             k, a, d, inf, m.lat, m.wr_cnt, m.wdata, m.err_cnt);
    chk("latency", m.lat, exp_lat);
    chk("busy_cycles", m.busy_cnt, exp_lat);
    chk("err_pulses", m.err_cnt, exp_err ? 1 : 0);
    chk("done_pulses", m.done_cnt, 1);
    chk("rd_pulses", m.rd_cnt, sub ? 1 : 0);
    chk("wr_pulses", m.wr_cnt, exp_err ? 0 : 1);
    if (!exp_err) begin
      chk("wr_addr", m.wr_addr, a & ~32'h3);
      chk("wdata", m.wdata, exp_w);
      chk("wr_cycle", m.wr_cyc, exp_lat - 1);
    end
    if (sub) begin
      chk("rd_addr", m.rd_addr, a & ~32'h3);
      chk("rd_cycle", m.rd_cyc, 1);
    end
    chk("stray_bus", m.stray, 0);
    chk("rd_wr_overlap", m.overlap, 0);
    chk("idle_after", m.idle_after, 1);
    chk("mem_word", mem[k][a[9:2]], exp_mem);
    lat = m.lat;
  endtask

  vec_t vecs[11];
  int   blat[N];

  initial begin
    mon_t m, m2;
    int   lat, wr_seen, elat;
    bit   err;
    bit [31:0] nw, a, d;
    bit [2:0]  inf;

    vecs[0]  = '{32'h11223344, 32'h100, 32'hDEADBEEF, 3'b010, 32'hDEADBEEF, 1'b0, 2};
    vecs[1]  = '{32'h11223344, 32'h102, 32'h000000AB, 3'b000, 32'h1122AB44, 1'b0, 4};
    vecs[2]  = '{32'h11223344, 32'h102, 32'hFFFFBEEF, 3'b001, 32'h1122BEEF, 1'b0, 4};
    vecs[3]  = '{32'h11223344, 32'h100, 32'hFFFFBEEF, 3'b101, 32'hBEEF3344, 1'b0, 4};
    vecs[4]  = '{32'h11223344, 32'h101, 32'hFFFFBEEF, 3'b001, 32'h11223344, 1'b1, 1};
    vecs[5]  = '{32'h11223344, 32'h102, 32'hDEADBEEF, 3'b010, 32'h11223344, 1'b1, 1};
    vecs[6]  = '{32'hCAFEF00D, 32'h104, 32'h12345678, 3'b011, 32'h12345678, 1'b0, 2};
    vecs[7]  = '{32'h11223344, 32'h103, 32'h99887766, 3'b100, 32'h11223366, 1'b0, 4};
    vecs[8]  = '{32'h11223344, 32'h100, 32'h000000CD, 3'b000, 32'hCD223344, 1'b0, 4};
    vecs[9]  = '{32'h11223344, 32'h101, 32'h0BADF00D, 3'b111, 32'h11223344, 1'b1, 1};
    vecs[10] = '{32'h11223344, 32'h101, 32'h000000EE, 3'b000, 32'h11EE3344, 1'b0, 4};

    for (int k = 0; k < N; k++) begin
      st_req_s[k] = 1'b0; st_addr_s[k] = '0; st_data_s[k] = '0; info_s[k] = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("reset_addr", mem_addr_s[k], 0);
      chk("reset_wdata", mem_wdata_s[k], 0);
      chk("reset_ctl", {mem_rd_s[k], mem_wr_s[k], busy_s[k], done_s[k], err_s[k]}, 0);
    end
    reset_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 11; i++) begin
        mem[k][vecs[i].a[9:2]] = vecs[i].init;
        elat = vecs[i].exp_lat1 + ((k == 1 && vecs[i].exp_lat1 == 4) ? 2 : 0);
        do_txn(k, vecs[i].a, vecs[i].d, vecs[i].inf, vecs[i].exp_err, vecs[i].exp_w,
               elat, vecs[i].exp_w, lat);
        if (i == 1) blat[k] = lat;
      end
    end
    chk("read_lat_delta", blat[1] - blat[0], 2);

    // Second request held high through WAIT and DONE must wait for IDLE.
    mem[1][8'h80] = 32'h01020304;
    mem[1][8'h81] = 32'hA0B0C0D0;
    @(negedge clk);
    st_req_s[1] = 1'b1; st_addr_s[1] = 32'h201; st_data_s[1] = 32'h00000055; info_s[1] = 3'b000;
    @(posedge clk);
    #1;
    st_addr_s[1] = 32'h206; st_data_s[1] = 32'h00007777; info_s[1] = 3'b001;
    monitor(1, m);
    $display("txn dut1 busy-hold first lat=%0d wdata=%h", m.lat, m.wdata);
    chk("hold_first_wdata", m.wdata, 32'h01550304);
    chk("hold_first_addr", m.wr_addr, 32'h200);
    chk("hold_first_lat", m.lat, 6);
    chk("hold_idle_gap", m.idle_after, 1);
    @(posedge clk);
    #1;
    st_req_s[1] = 1'b0;
    monitor(1, m2);
    $display("txn dut1 busy-hold second lat=%0d wdata=%h", m2.lat, m2.wdata);
    chk("hold_second_wdata", m2.wdata, 32'hA0B07777);
    chk("hold_second_addr", m2.wr_addr, 32'h204);
    chk("hold_second_lat", m2.lat, 6);
    chk("hold_mem_first", mem[1][8'h80], 32'h01550304);

    // Reset during WAIT abandons the store with no write.
    mem[1][8'h40] = 32'h11223344;
    issue(1, 32'h102, 32'h000000AB, 3'b000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_addr", mem_addr_s[1], 0);
    chk("midrst_wdata", mem_wdata_s[1], 0);
    chk("midrst_ctl", {mem_rd_s[1], mem_wr_s[1], busy_s[1], done_s[1], err_s[1]}, 0);
    wr_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_wr_s[1] || busy_s[1]) wr_seen++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (mem_wr_s[1] || busy_s[1]) wr_seen++;
    end
    $display("txn dut1 reset-abort activity=%0d", wr_seen);
    chk("midrst_no_write", wr_seen, 0);
    chk("midrst_mem_intact", mem[1][8'h40], 32'h11223344);
    do_txn(1, 32'h102, 32'h000000AB, 3'b000, 1'b0, 32'h1122AB44, 6, 32'h1122AB44, lat);

    // Randomized stores against the reference memory.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 256; i++) begin
        mem[k][i]  = $urandom;
        refm[k][i] = mem[k][i];
      end
    for (int t = 0; t < 150; t++) begin
      int k;
      k   = $urandom_range(0, N - 1);
      a   = $urandom_range(0, 1023);
      d   = $urandom;
      inf = 3'($urandom_range(0, 7));
      model(refm[k][a[9:2]], a, d, inf, (k == 0) ? 1 : 3, err, nw, elat);
      do_txn(k, a, d, inf, err, nw, elat, nw, lat);
      refm[k][a[9:2]] = nw;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
